// File: rtl/hex_display_pkg.sv
// hex_display_pkg: seven-segment glyph type and active-low glyph constants (bit order gfedcba)
package hex_display_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: combinational nibble to active-low seven-segment glyph
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);
  always_comb begin
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/hex_display.sv
// hex_display: registered NUM_HEX-digit hex driver for HEX0..HEX5, unused digits blank.
// Optional HEX_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits (HEX0 always shown).
module hex_display
  import hex_display_pkg::*;
#(
  parameter int NUM_HEX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NUM_HEX-1:0]   num,
  output logic [6:0]             HEX0,
  output logic [6:0]             HEX1,
  output logic [6:0]             HEX2,
  output logic [6:0]             HEX3,
  output logic [6:0]             HEX4,
  output logic [6:0]             HEX5
);
  logic [NUM_HEX-1:0][6:0] dec;
  logic [5:0][6:0]         hex_d;
  logic [5:0][6:0]         hex_q;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
  logic                    zero_hi;
`endif
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_dec
    hex_seg_decoder u_dec (.nib(num[4*i +: 4]), .seg(dec[i]));
  end
  // Walk from the most significant active digit down so zero_hi means "this and all higher are zero"
  always_comb begin
    hex_d = {6{SEG_BLANK}};
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    zero_hi = 1'b1;
`endif
    for (int k = NUM_HEX - 1; k >= 0; k--) begin
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
      zero_hi = zero_hi & (num[4*k +: 4] == 4'h0);
      hex_d[k] = (zero_hi && k != 0) ? SEG_BLANK : dec[k];
`else
      hex_d[k] = dec[k];
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex_q <= {6{SEG_BLANK}};
    else hex_q <= hex_d;
  end
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
endmodule

// File: tb/tb_hex_display.sv
// tb_hex_display: directed plus random checks of 6-digit and 3-digit hex_display against a table model
module tb_hex_display;
  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] num6 = '0;
  logic [11:0] num3 = '0;
  logic [23:0] applied6 = '0;
  logic [11:0] applied3 = '0;
  logic [6:0]  h6 [6];
  logic [6:0]  h3 [6];
  int checks = 0;
  int errors = 0;
  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  hex_display #(.NUM_HEX(6)) u6 (.clk(clk), .rst(rst), .num(num6),
    .HEX0(h6[0]), .HEX1(h6[1]), .HEX2(h6[2]), .HEX3(h6[3]), .HEX4(h6[4]), .HEX5(h6[5]));
  hex_display #(.NUM_HEX(3)) u3 (.clk(clk), .rst(rst), .num(num3),
    .HEX0(h3[0]), .HEX1(h3[1]), .HEX2(h3[2]), .HEX3(h3[3]), .HEX4(h3[4]), .HEX5(h3[5]));

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [6:0] exp_seg(input int n, input logic [23:0] v, input int k);
    logic [23:0] active;
    if (k >= n) return 7'b1111111;
    active = (n == 6) ? v : (v & ((24'h1 << (4 * n)) - 24'h1));
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    if (k > 0 && (active >> (4 * k)) == 24'h0) return 7'b1111111;
`endif
    return glyph[(active >> (4 * k)) & 24'hF];
  endfunction

  task automatic cmp(input string tag, input int k, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s HEX%0d got %b exp %b", tag, k, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 6; k++) begin
      cmp({tag, "/n6"}, k, h6[k], exp_seg(6, applied6, k));
      cmp({tag, "/n3"}, k, h3[k], exp_seg(3, {12'h0, applied3}, k));
    end
  endtask

  task automatic check_blank(input string tag);
    for (int k = 0; k < 6; k++) begin
      cmp({tag, "/n6"}, k, h6[k], 7'b1111111);
      cmp({tag, "/n3"}, k, h3[k], 7'b1111111);
    end
  endtask

  task automatic step();
    applied6 = num6;
    applied3 = num3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5 rst = 1'b1;
    #1 check_blank("reset_noclk");
    num6 = 24'h123456;
    num3 = 12'h9A0;
    clk_en = 1'b1;
    step();
    step();
    check_blank("reset_held");
    @(negedge clk);
    rst = 1'b0;
    #1 check_blank("reset_release");
    step();
    check_all("h123456");
    cmp("lit123456", 5, h6[5], 7'b1111001);
    cmp("lit123456", 0, h6[0], 7'b0000010);
    num6 = 24'hFEDCBA;
    step();
    check_all("hFEDCBA");
    cmp("litFEDCBA", 3, h6[3], 7'b0100001);
    num6 = 24'h789CBA;
    step();
    check_all("h789CBA");
    cmp("lit789CBA", 4, h6[4], 7'b0000000);
    cmp("lit9A0", 1, h3[1], 7'b0001000);
    num6 = 24'h000000;
    step();
    check_all("zero");
    num6 = 24'h000001;
    #1 cmp("latency_before", 0, h6[0], 7'b1000000);
    step();
    cmp("latency_after", 0, h6[0], 7'b1111001);
    num3 = 12'h005;
    num6 = 24'h000A05;
    step();
    check_all("h005");
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    cmp("lzb005", 1, h3[1], 7'b1111111);
    cmp("lzbA05", 2, h6[2], 7'b0001000);
    cmp("lzbA05", 1, h6[1], 7'b1000000);
`else
    cmp("nolzb005", 1, h3[1], 7'b1000000);
`endif
    cmp("h005_d0", 0, h3[0], 7'b0010010);
    for (int i = 0; i < 200; i++) begin
      num6 = 24'($urandom >> $urandom_range(8, 31));
      num3 = 12'($urandom >> $urandom_range(20, 31));
      step();
      check_all("random");
    end
    rst = 1'b1;
    #1 check_blank("reset_async_mid");
    rst = 1'b0;
    step();
    check_all("post_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
